// File: rtl/ovl_fabric_pkg.sv
// Shared types and cfg_data field layout for the checker-fabric config controller.
package ovl_fabric_pkg;

  // Controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Index width the fabric is normally built with.
  localparam int DEFAULT_IDX_W = 4;

  // cfg_data layout: {enable, sampling_event index, test_expr index}.
  localparam int CFG_TIDX_LSB = 0;

  function automatic int cfg_data_w(input int idx_w);
    return 2 * idx_w + 1;
  endfunction

  function automatic int cfg_sidx_lsb(input int idx_w);
    return idx_w;
  endfunction

  function automatic int cfg_en_bit(input int idx_w);
    return 2 * idx_w;
  endfunction

  // Enable bit position for the default build.
  localparam int CFG_EN_BIT = 2 * DEFAULT_IDX_W;

endpackage

// File: rtl/ovl_sig_select.sv
// Picks one bit out of the monitored signal pool; indices past the pool read 0.
module ovl_sig_select #(
  parameter int SIG_W = 16,
  parameter int IDX_W = 4
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             sel_o
);

  localparam int EXT_W = 2 ** IDX_W;

  // Zero-extending the pool to the full index range makes out-of-range picks 0.
  logic [EXT_W-1:0] pool_ext;

  assign pool_ext = EXT_W'(sig_i);
  assign sel_o    = pool_ext[idx_i];

endmodule

// File: rtl/ovl_fabric_cfg_ctrl.sv
// Configuration sequencer and error collector for a bank of always-on-edge checkers.
module ovl_fabric_cfg_ctrl
  import ovl_fabric_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SIG_W      = 16,
  parameter int IDX_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [2*IDX_W:0]        cfg_data,
  input  logic [SIG_W-1:0]        sig_pool,
  output logic [NUM_SLOTS-1:0]    slot_enable,
  output logic [NUM_SLOTS-1:0]    slot_sample,
  output logic [NUM_SLOTS-1:0]    slot_test,
  output logic [NUM_SLOTS-1:0]    slot_cfg_invalid,
  input  logic [NUM_SLOTS-1:0]    slot_fire,
  input  logic                    err_clr,
  output logic [NUM_SLOTS-1:0]    err_flags,
  output logic                    first_err_valid,
  output logic [IDX_W-1:0]        first_err_slot,
  output logic                    irq,
  output logic                    active
);

  localparam int CNT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam int EN_BIT   = cfg_en_bit(IDX_W);
  localparam int SIDX_LSB = cfg_sidx_lsb(IDX_W);

  localparam logic [CNT_W-1:0] LAST_SLOT   = CNT_W'(NUM_SLOTS - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYC - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [NUM_SLOTS-1:0] en_q;
  logic [IDX_W-1:0]     sidx_q [NUM_SLOTS];
  logic [IDX_W-1:0]     tidx_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] err_q, err_d;
  logic                 fv_q, fv_d;
  logic [IDX_W-1:0]     fslot_q, fslot_d;
  logic                 irq_q;

  logic                 accept;
  logic [NUM_SLOTS-1:0] fire_qual;
  logic [NUM_SLOTS-1:0] err_base;
  logic                 fv_base;
  logic [IDX_W-1:0]     lowest_fire;

  assign accept = cfg_valid && cfg_ready;

  // State and load/settle counters.
  // NOTE: sequential state uses <= so every register samples the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  // Next-state: start a load, count accepted words, hold SETTLE for SETTLE_CYC cycles.
  // NOTE: every variable gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (cnt_q == LAST_SLOT) begin
            state_d  = ST_SETTLE;
            cnt_d    = '0;
            settle_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == LAST_SETTLE) begin
          state_d = ST_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (cfg_start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Per-slot configuration registers, written one slot per accepted word.
  // NOTE: these small register arrays are reset so a partial load never survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        sidx_q[i] <= '0;
        tidx_q[i] <= '0;
      end
    end else if (accept) begin
      en_q[cnt_q]   <= cfg_data[EN_BIT];
      sidx_q[cnt_q] <= cfg_data[SIDX_LSB +: IDX_W];
      tidx_q[cnt_q] <= cfg_data[CFG_TIDX_LSB +: IDX_W];
    end
  end

  // Checker-facing controls decoded from the registered state.
  assign cfg_ready        = (state_q == ST_LOAD);
  assign active           = (state_q == ST_RUN);
  assign slot_enable      = (state_q == ST_SETTLE || state_q == ST_RUN) ? en_q : '0;
  assign slot_cfg_invalid = {NUM_SLOTS{state_q != ST_RUN}};

  // Route the selected pool bits to each checker.
  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_route
    ovl_sig_select #(.SIG_W(SIG_W), .IDX_W(IDX_W)) u_sample (
      .sig_i (sig_pool),
      .idx_i (sidx_q[g]),
      .sel_o (slot_sample[g])
    );
    ovl_sig_select #(.SIG_W(SIG_W), .IDX_W(IDX_W)) u_test (
      .sig_i (sig_pool),
      .idx_i (tidx_q[g]),
      .sel_o (slot_test[g])
    );
  end

  // Only enabled slots fire, and only while running.
  assign fire_qual = (state_q == ST_RUN) ? (slot_fire & en_q) : '0;

  // Lowest-index qualified fire for first-error capture.
  always_comb begin
    lowest_fire = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (fire_qual[i]) lowest_fire = IDX_W'(i);
    end
  end

  // Error next-state: clear first, then a same-cycle fire sets and recaptures.
  always_comb begin
    err_base = err_clr ? '0 : err_q;
    fv_base  = err_clr ? 1'b0 : fv_q;
    err_d    = err_base | fire_qual;
    fv_d     = fv_base;
    fslot_d  = fslot_q;
    if ((fire_qual != '0) && (err_base == '0) && !fv_base) begin
      fv_d    = 1'b1;
      fslot_d = lowest_fire;
    end
    if (state_q != ST_LOAD && state_d == ST_LOAD) begin
      err_d = '0;
      fv_d  = 1'b0;
    end
  end

  // Error registers; irq tracks the OR of the flags being registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      fv_q    <= 1'b0;
      fslot_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      err_q   <= err_d;
      fv_q    <= fv_d;
      fslot_q <= fslot_d;
      irq_q   <= |err_d;
    end
  end

  assign err_flags       = err_q;
  assign first_err_valid = fv_q;
  assign first_err_slot  = fslot_q;
  assign irq             = irq_q;

endmodule

// File: tb/tb_ovl_fabric_cfg_ctrl.sv
// Directed table-driven bench for ovl_fabric_cfg_ctrl (default parameters).
module tb_ovl_fabric_cfg_ctrl;

  localparam logic [3:0] F  = 4'hF;
  localparam logic [3:0] B  = 4'b1011;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_valid, cfg_ready;
  logic [8:0] cfg_data;
  logic [15:0] sig_pool;
  logic [3:0] slot_enable, slot_sample, slot_test, slot_cfg_invalid, slot_fire;
  logic       err_clr;
  logic [3:0] err_flags;
  logic       first_err_valid;
  logic [3:0] first_err_slot;
  logic       irq, active;

  int checks = 0;
  int errors = 0;

  // Routing configured by the standard load: {2,4,0,15} / {3,5,0,1}.
  int s_idx[4] = '{2, 4, 0, 15};
  int t_idx[4] = '{3, 5, 0, 1};

  typedef struct {
    logic       start;
    logic       valid;
    logic [8:0] data;
    logic [3:0] fire;
    logic       clr;
    logic       rdy;
    logic [3:0] en;
    logic [3:0] inv;
    logic       act;
    logic [3:0] err;
    logic       fv;
    logic [3:0] fs;
    logic       irq;
  } vec_t;

  vec_t vq[$];

  ovl_fabric_cfg_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_data         (cfg_data),
    .sig_pool         (sig_pool),
    .slot_enable      (slot_enable),
    .slot_sample      (slot_sample),
    .slot_test        (slot_test),
    .slot_cfg_invalid (slot_cfg_invalid),
    .slot_fire        (slot_fire),
    .err_clr          (err_clr),
    .err_flags        (err_flags),
    .first_err_valid  (first_err_valid),
    .first_err_slot   (first_err_slot),
    .irq              (irq),
    .active           (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {ready, enable, invalid, active, err_flags, first_valid, first_slot, irq}
  function automatic logic [31:0] pk(input logic rdy, input logic [3:0] en, input logic [3:0] inv,
                                     input logic act, input logic [3:0] err, input logic fv,
                                     input logic [3:0] fs, input logic irq_v);
    return {12'd0, rdy, en, inv, act, err, fv, fs, irq_v};
  endfunction

  function automatic logic [31:0] dut_pk();
    return pk(cfg_ready, slot_enable, slot_cfg_invalid, active, err_flags,
              first_err_valid, first_err_slot, irq);
  endfunction

  task automatic add(input logic st, input logic vl, input logic [8:0] d, input logic [3:0] fi,
                     input logic cl, input logic rdy, input logic [3:0] en, input logic [3:0] inv,
                     input logic act, input logic [3:0] err, input logic fv, input logic [3:0] fs,
                     input logic iq);
    vec_t v;
    v.start = st; v.valid = vl; v.data = d; v.fire = fi; v.clr = cl;
    v.rdy = rdy; v.en = en; v.inv = inv; v.act = act;
    v.err = err; v.fv = fv; v.fs = fs; v.irq = iq;
    vq.push_back(v);
  endtask

  // Drive each record at the falling edge, compare just after the next rising edge.
  task automatic run_table(input string tag);
    foreach (vq[i]) begin
      @(negedge clk);
      cfg_start = vq[i].start;
      cfg_valid = vq[i].valid;
      cfg_data  = vq[i].data;
      slot_fire = vq[i].fire;
      err_clr   = vq[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("%s_vec%0d", tag, i), dut_pk(),
            pk(vq[i].rdy, vq[i].en, vq[i].inv, vq[i].act,
               vq[i].err, vq[i].fv, vq[i].fs, vq[i].irq));
    end
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b0; slot_fire = '0; err_clr = 1'b0;
    vq.delete();
  endtask

  initial begin
    logic [15:0] pats[5];
    logic [3:0]  es, et;
    pats = '{16'h0004, 16'h8020, 16'h0009, 16'hFFFF, 16'h0000};

    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    sig_pool = '0; slot_fire = '0; err_clr = 1'b0;

    // Reset held three cycles, then idle.
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", dut_pk(), pk(0, 0, F, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle", dut_pk(), pk(0, 0, F, 0, 0, 0, 0, 0));

    // Continuous load, settle, run, error capture, clear collision, reconfig,
    // backpressured reload with junk data on idle cycles.
    add(1, 0, 9'h000, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h123, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h145, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h000, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h1F1, 4'h0, 0,  0, B, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h000, 4'h0, 0,  0, B, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h000, 4'h0, 0,  0, B, 0, 1,  4'h0, 0, 0, 0);
    add(0, 0, 9'h000, 4'hA, 0,  0, B, 0, 1,  4'hA, 1, 1, 1);
    add(0, 0, 9'h000, 4'h1, 0,  0, B, 0, 1,  4'hB, 1, 1, 1);
    add(0, 0, 9'h000, 4'h4, 0,  0, B, 0, 1,  4'hB, 1, 1, 1);
    add(0, 0, 9'h000, 4'h8, 1,  0, B, 0, 1,  4'h8, 1, 3, 1);
    add(0, 0, 9'h000, 4'h0, 1,  0, B, 0, 1,  4'h0, 0, 3, 0);
    add(0, 0, 9'h000, 4'h1, 0,  0, B, 0, 1,  4'h1, 1, 0, 1);
    add(1, 0, 9'h000, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h1FF, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h123, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h1FF, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h145, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h1FF, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h000, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h1FF, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h1F1, 4'h0, 0,  0, B, F, 0,  4'h0, 0, 0, 0);
    add(1, 0, 9'h000, 4'h0, 0,  0, B, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h000, 4'h1, 0,  0, B, 0, 1,  4'h0, 0, 0, 0);
    run_table("load");

    // Signal routing in RUN against the configured indices.
    foreach (pats[p]) begin
      @(negedge clk);
      sig_pool = pats[p];
      #1;
      for (int i = 0; i < 4; i++) begin
        es[i] = pats[p][s_idx[i]];
        et[i] = pats[p][t_idx[i]];
      end
      check($sformatf("route_sample_%0d", p), {28'd0, slot_sample}, {28'd0, es});
      check($sformatf("route_test_%0d", p),   {28'd0, slot_test},   {28'd0, et});
    end

    // Reconfigure, accept two words, then reset asynchronously mid-load.
    @(negedge clk);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    check("reload_enter", dut_pk(), pk(1, 0, F, 0, 0, 0, 0, 0));
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b1; cfg_data = 9'h155;
    @(negedge clk);
    cfg_data = 9'h166;
    @(negedge clk);
    cfg_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", dut_pk(), pk(0, 0, F, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    sig_pool = 16'h0001;
    #1;
    check("cfg_cleared_sample", {28'd0, slot_sample}, {28'd0, F});
    check("cfg_cleared_test",   {28'd0, slot_test},   {28'd0, F});

    // Fresh load after reset needs all four words again.
    add(0, 1, 9'h1F1, 4'h0, 0,  0, 0, F, 0,  4'h0, 0, 0, 0);
    add(1, 0, 9'h000, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h123, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h145, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h000, 4'h0, 0,  1, 0, F, 0,  4'h0, 0, 0, 0);
    add(0, 1, 9'h1F1, 4'h0, 0,  0, B, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h000, 4'h0, 0,  0, B, F, 0,  4'h0, 0, 0, 0);
    add(0, 0, 9'h000, 4'h0, 0,  0, B, 0, 1,  4'h0, 0, 0, 0);
    run_table("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
